// File: rtl/term1_rq_pkg.sv
// Shared types and constants for the term1 result queue.
package term1_rq_pkg;

    // Bit positions inside the term1 result vector.
    localparam int unsigned J0_BIT = 0;
    localparam int unsigned K0_BIT = 1;
    localparam int unsigned L0_BIT = 2;
    localparam int unsigned M0_BIT = 3;
    localparam int unsigned N0_BIT = 4;
    localparam int unsigned O0_BIT = 5;
    localparam int unsigned P0_BIT = 6;
    localparam int unsigned Q0_BIT = 7;
    localparam int unsigned R0_BIT = 8;
    localparam int unsigned S0_BIT = 9;
    localparam int unsigned RES_W  = 10;

    typedef logic [RES_W-1:0] res_t;

    typedef struct packed {
        res_t data;
        logic changed;
    } entry_t;

    // Occupancy view of the queue, derived from the level counter.
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } occ_e;

endpackage

// File: rtl/term1_result_queue_if.sv
// Producer/consumer handshake bundle for term1_result_queue.
// master = the side that produces and consumes words, slave = the queue.
interface term1_result_queue_if #(
    parameter int unsigned W = term1_rq_pkg::RES_W
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_changed;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_changed
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_changed
    );
endinterface

// File: rtl/term1_rq_mem.sv
// Entry storage for the result queue: synchronous write, asynchronous read.
// The array itself has no reset; validity is tracked by the queue's level.
module term1_rq_mem
    import term1_rq_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  entry_t           wentry,
    input  logic [PTR_W-1:0] raddr,
    output entry_t           rentry
);
    entry_t mem [DEPTH];

    // Write the pushed entry at the write pointer.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wentry;
        end
    end

    assign rentry = mem[raddr];
endmodule

// File: rtl/term1_result_queue.sv
// Result queue behind the term1 combinational logic: buffers result vectors,
// flags each word that differs from the previous capture and counts them.
// Optional feature macro: TERM1_RQ_OVF_EN adds a sticky overflow output.
module term1_result_queue
    import term1_rq_pkg::*;
#(
    parameter int unsigned W     = RES_W,  // must equal RES_W
    parameter int unsigned DEPTH = 4,      // power of 2, >= 2
    parameter int unsigned CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    term1_result_queue_if.slave      bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         chg_cnt
`ifdef TERM1_RQ_OVF_EN
    ,
    output logic                     ovf
`endif
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic [CNT_W-1:0] chg_cnt_q;
    logic [W-1:0]     last_word_q;
    logic             first_q;
    occ_e             occ;
    logic             push, pop, changed;
    entry_t           wentry, rentry;

    // Classify occupancy; handshake flags come only from the level register.
    always_comb begin
        occ = PARTIAL;
        if (level_q == '0) begin
            occ = EMPTY;
        end else if (level_q == LVL_W'(DEPTH)) begin
            occ = FULL;
        end
    end

    assign bus.in_ready  = (occ != FULL);
    assign bus.out_valid = (occ != EMPTY);
    assign push          = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;
    assign changed       = first_q | (bus.in_data != last_word_q);

    assign wentry.data    = res_t'(bus.in_data);
    assign wentry.changed = changed;

    term1_rq_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk    (clk),
        .we     (push),
        .waddr  (wr_ptr_q),
        .wentry (wentry),
        .raddr  (rd_ptr_q),
        .rentry (rentry)
    );

    // Outputs read as zero while empty so reset leaves them clean.
    assign bus.out_data    = bus.out_valid ? W'(rentry.data) : '0;
    assign bus.out_changed = bus.out_valid & rentry.changed;
    assign level           = level_q;
    assign chg_cnt         = chg_cnt_q;

    // Pointers, occupancy, change tracking and saturating change counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            chg_cnt_q   <= '0;
            last_word_q <= '0;
            first_q     <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_q    <= wr_ptr_q + PTR_W'(1);
                last_word_q <= bus.in_data;
                first_q     <= 1'b0;
                if (changed && (chg_cnt_q != {CNT_W{1'b1}})) begin
                    chg_cnt_q <= chg_cnt_q + CNT_W'(1);
                end
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

`ifdef TERM1_RQ_OVF_EN
    // Sticky flag: a word was offered while the queue was full.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (bus.in_valid && !bus.in_ready) begin
            ovf <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_term1_result_queue.sv
// Directed bench for term1_result_queue (main DUT with DEPTH=4, CNT_W=8 and a
// second DUT with CNT_W=2 for counter saturation). Honours TERM1_RQ_OVF_EN.
module tb_term1_result_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    term1_result_queue_if #(.W(10)) bus ();
    term1_result_queue_if #(.W(10)) bus2 ();

    logic [2:0] level, level2;
    logic [7:0] chg_cnt;
    logic [1:0] chg_cnt2;
`ifdef TERM1_RQ_OVF_EN
    logic ovf, ovf2;
`endif

    term1_result_queue #(.W(10), .DEPTH(4), .CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .level   (level),
        .chg_cnt (chg_cnt)
`ifdef TERM1_RQ_OVF_EN
        ,
        .ovf     (ovf)
`endif
    );

    term1_result_queue #(.W(10), .DEPTH(4), .CNT_W(2)) dut2 (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus2),
        .level   (level2),
        .chg_cnt (chg_cnt2)
`ifdef TERM1_RQ_OVF_EN
        ,
        .ovf     (ovf2)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic push_word(input logic [9:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (chg_cnt !== 8'd0) begin failures++; $display("FAIL reset_chg_cnt got=%0d exp=0", chg_cnt); end
        checks++; if (bus.out_data !== 10'h000) begin failures++; $display("FAIL reset_out_data got=%h exp=000", bus.out_data); end
`ifdef TERM1_RQ_OVF_EN
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
    endtask

    task automatic test_single_push();
        do_reset();
        push_word(10'h3FF);
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_data !== 10'h3FF) begin failures++; $display("FAIL single_data got=%h exp=3ff", bus.out_data); end
        checks++; if (bus.out_changed !== 1'b1) begin failures++; $display("FAIL single_changed got=%b exp=1", bus.out_changed); end
        checks++; if (level !== 3'd1) begin failures++; $display("FAIL single_level got=%0d exp=1", level); end
        checks++; if (chg_cnt !== 8'd1) begin failures++; $display("FAIL single_chg_cnt got=%0d exp=1", chg_cnt); end
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL single_hold_valid got=%b exp=1", bus.out_valid); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL single_drain_valid got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [9:0] words [3];
        logic       flags [3];
        words = '{10'h001, 10'h001, 10'h002};
        flags = '{1'b1, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = words[i];
            tick();
        end
        bus.in_valid = 1'b0;
        checks++; if (level !== 3'd3) begin failures++; $display("FAIL b2b_level got=%0d exp=3", level); end
        checks++; if (chg_cnt !== 8'd2) begin failures++; $display("FAIL b2b_chg_cnt got=%0d exp=2", chg_cnt); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, bus.out_valid); end
            checks++; if (bus.out_data !== words[i]) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, bus.out_data, words[i]); end
            checks++; if (bus.out_changed !== flags[i]) begin failures++; $display("FAIL b2b_changed[%0d] got=%b exp=%b", i, bus.out_changed, flags[i]); end
            tick();
        end
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_full();
        logic [9:0] words [4];
        words = '{10'h0A1, 10'h0B2, 10'h0C3, 10'h0D4};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL full_ready_fill[%0d] got=%b exp=1", i, bus.in_ready); end
            push_word(words[i]);
        end
        checks++; if (level !== 3'd4) begin failures++; $display("FAIL full_level got=%0d exp=4", level); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", bus.in_ready); end
        push_word(10'h155);
        checks++; if (level !== 3'd4) begin failures++; $display("FAIL full_extra_level got=%0d exp=4", level); end
        checks++; if (chg_cnt !== 8'd4) begin failures++; $display("FAIL full_chg_cnt got=%0d exp=4", chg_cnt); end
`ifdef TERM1_RQ_OVF_EN
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL full_ovf got=%b exp=1", ovf); end
`endif
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.out_data !== words[i]) begin failures++; $display("FAIL full_drain[%0d] got=%h exp=%h", i, bus.out_data, words[i]); end
            checks++; if (level !== 3'(4 - i)) begin failures++; $display("FAIL full_drain_level[%0d] got=%0d exp=%0d", i, level, 4 - i); end
            tick();
        end
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL full_empty got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_wrap();
        do_reset();
        push_word(10'h100);
        push_word(10'h101);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 10'(10'h102 + i);
            checks++; if (level !== 3'd2) begin failures++; $display("FAIL wrap_level[%0d] got=%0d exp=2", i, level); end
            checks++; if (bus.out_data !== 10'(10'h100 + i)) begin failures++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, bus.out_data, 10'(10'h100 + i)); end
            tick();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (bus.out_data !== 10'(10'h10A + i)) begin failures++; $display("FAIL wrap_tail[%0d] got=%h exp=%h", i, bus.out_data, 10'(10'h10A + i)); end
            tick();
        end
        bus.out_ready = 1'b0;
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL wrap_end_level got=%0d exp=0", level); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        push_word(10'h011);
        push_word(10'h022);
        push_word(10'h033);
        push_word(10'h044);
        push_word(10'h055);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++; if (level !== 3'd3) begin failures++; $display("FAIL midrst_pre_level got=%0d exp=3", level); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (level !== 3'd0) begin failures++; $display("FAIL midrst_level got=%0d exp=0", level); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", bus.out_valid); end
        checks++; if (chg_cnt !== 8'd0) begin failures++; $display("FAIL midrst_chg_cnt got=%0d exp=0", chg_cnt); end
`ifdef TERM1_RQ_OVF_EN
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL midrst_ovf got=%b exp=0", ovf); end
`endif
        push_word(10'h000);
        checks++; if (bus.out_data !== 10'h000) begin failures++; $display("FAIL midrst_data got=%h exp=000", bus.out_data); end
        checks++; if (bus.out_changed !== 1'b1) begin failures++; $display("FAIL midrst_changed got=%b exp=1", bus.out_changed); end
        checks++; if (level !== 3'd1) begin failures++; $display("FAIL midrst_post_level got=%0d exp=1", level); end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        bus2.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus2.in_valid = 1'b1;
            bus2.in_data  = i[0] ? 10'h155 : 10'h2AA;
            tick();
            checks++; if (chg_cnt2 !== exp_cnt[i]) begin failures++; $display("FAIL sat_cnt[%0d] got=%0d exp=%0d", i, chg_cnt2, exp_cnt[i]); end
        end
        bus2.in_valid  = 1'b0;
        bus2.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.in_data   = '0;
        bus2.out_ready = 1'b0;
        test_reset();
        test_single_push();
        test_back_to_back();
        test_full();
        test_wrap();
        test_mid_reset();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
